// File: rtl/flash_sched.sv
// flash_sched: round-robin LED flash scheduler; define FLASH_SCHED_LATCH_EN to latch request edges
module flash_sched #(
  parameter int NREQ = 4,
  parameter int ON_CYC = 4,
  parameter int OFF_CYC = 4,
  parameter int BLINKS = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic            ld,
  output logic            busy,
  output logic [NREQ-1:0] gnt,
  output logic            done
);
  localparam int MX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int PW = (MX > 1) ? $clog2(MX) : 1;
  localparam int BW = (BLINKS > 1) ? $clog2(BLINKS) : 1;
  localparam int AW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
  state_t state, nstate;
  logic [PW-1:0] cnt, ncnt;
  logic [BW-1:0] blk, nblk;
  logic [AW-1:0] ptr, win, idx;
  logic [NREQ-1:0] elig, pick;
  logic take;
  assign take = (state == IDLE) && |elig;
  assign pick = {{(NREQ-1){1'b0}}, 1'b1} << win;
  assign ld = state == ON;
  assign busy = state != IDLE;
`ifdef FLASH_SCHED_LATCH_EN
  logic [NREQ-1:0] pending, req_q;
  assign elig = pending;
  always_ff @(posedge clk)
    if (rst) begin
      pending <= '0;
      req_q <= '0;
    end else begin
      pending <= (pending & ~(take ? pick : '0)) | (req & ~req_q);
      req_q <= req;
    end
`else
  assign elig = req;
`endif
  always_comb begin
    win = ptr;
    idx = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = AW'((int'(ptr) + k) % NREQ);
      if (elig[idx]) win = idx;
    end
  end
  always_comb begin
    nstate = state;
    ncnt = cnt + 1'b1;
    nblk = blk;
    unique case (state)
      IDLE: begin
        ncnt = '0;
        nblk = '0;
        if (|elig) nstate = ON;
      end
      ON: if (cnt == PW'(ON_CYC - 1)) begin
        nstate = OFF;
        ncnt = '0;
      end
      OFF: if (cnt == PW'(OFF_CYC - 1)) begin
        ncnt = '0;
        if (blk == BW'(BLINKS - 1)) nstate = IDLE;
        else begin
          nstate = ON;
          nblk = blk + 1'b1;
        end
      end
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      blk <= '0;
      ptr <= '0;
      gnt <= '0;
      done <= 1'b0;
    end else begin
      state <= nstate;
      cnt <= ncnt;
      blk <= nblk;
      done <= (state == OFF) && (nstate == IDLE);
      if (take) begin
        gnt <= pick;
        ptr <= (win == AW'(NREQ - 1)) ? '0 : win + 1'b1;
      end else if (nstate == IDLE) gnt <= '0;
    end
endmodule

// File: doc/flash_sched.md
# flash_sched

Round-robin scheduler that shares one LED flash engine between `NREQ` switch-style requesters. When a requester is granted, the block drives `ld` through `BLINKS` on/off cycles of fixed length, then releases the engine and picks the next requester. It sits between the switch inputs and the board LED, in place of wiring a single `sw` straight to a `flash` unit.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (legal range 2..8)
- `ON_CYC`, 4, clock cycles `ld` is high per blink (≥1)
- `OFF_CYC`, 4, clock cycles `ld` is low per blink (≥1)
- `BLINKS`, 3, blinks per grant (≥1)

Ports:
- `clk` in 1: single clock; all state updates on the rising edge
- `rst` in 1: synchronous, active-high reset
- `req` in `NREQ`: request lines, one per requester; level sensitive unless `FLASH_SCHED_LATCH_EN` is defined
- `ld` out 1: LED drive
- `busy` out 1: high while a grant is active (states ON and OFF)
- `gnt` out `NREQ`: one-hot owner of the engine; all zero when idle
- `done` out 1: one-cycle pulse when a grant completes

## Operation
- FSM states:
  - IDLE: `ld`=0, `busy`=0, `gnt`=0.
  - ON: `ld`=1.
  - OFF: `ld`=0.
- Eligible vector `elig`: equals `req` (level mode), or equals the `pending` register (latch mode).
- IDLE to ON:
  - Taken when `elig` is nonzero.
  - Winner is the first set bit scanning upward, with wrap, from `ptr`.
  - `gnt` is loaded one-hot with the winner.
  - `ptr` is set to winner+1 mod `NREQ`.
  - The phase counter and the blink counter are cleared.
- ON to OFF: after `ON_CYC` cycles in ON.
- OFF to ON: after `OFF_CYC` cycles in OFF, provided the blink count is below `BLINKS`-1; the blink count is incremented.
- OFF to IDLE: after `OFF_CYC` cycles in OFF on the last blink. `gnt` is cleared and `done`=1 for exactly that first IDLE cycle.
- `gnt` is held constant for the whole grant. Changes on `req` during ON/OFF do not affect the active sequence.
- Phase counter width: `$clog2(max(ON_CYC,OFF_CYC))`, minimum 1 bit. Blink counter width: `$clog2(BLINKS)`, minimum 1 bit. Neither counter wraps within a legal sequence.
- Reset values: state=IDLE, `ld`=0, `busy`=0, `gnt`=0, `done`=0, `ptr`=0 (requester 0 highest priority), `pending`=0, edge register=0.
- Reset mid-grant: the sequence aborts in the next cycle. No `done` pulse is issued and no pending bit is kept.

## Timing
- Request seen in IDLE at edge t gives `gnt`, `busy` and `ld`=1 from cycle t+1. Grant latency is 1 cycle.
- Grant duration: exactly `BLINKS`*(`ON_CYC`+`OFF_CYC`) cycles of `busy`=1.
- `done` overlaps the first IDLE cycle. Arbitration also runs in that cycle, so back-to-back grants have exactly one IDLE cycle between them. `ld` is low for `OFF_CYC`+1 cycles between owners.
- All outputs are registered. There are no combinational paths from `req` to any output.
- Simultaneous requests: round-robin order starting from `ptr`. No requester is served twice while another eligible one waits.

## Configuration
- `FLASH_SCHED_LATCH_EN` defined:
  - A rising edge on `req[i]` sets `pending[i]`. The edge is detected against a registered copy of `req`.
  - The granted bit of `pending` is cleared on the grant edge.
  - If a new rising edge arrives on the same bit in the same cycle as its clear, set wins.
  - Requests pulsed for a single cycle during a busy grant are served later.
- `FLASH_SCHED_LATCH_EN` not defined:
  - No `pending` or edge registers are built.
  - A requester is served only if its `req` is high in an IDLE cycle.
  - A requester holding `req` high is re-served each time its round-robin turn arrives.

## Test plan
- Reset, then `req`=4'b0001 held 1 cycle (defaults):
  - `gnt`=0001 and `ld` high on cycles 1–4, 9–12, 17–20.
  - `busy` high on cycles 1–24.
  - `done`=1 at cycle 25.
  - `ptr`=1.
- `req`=4'b1111 held high:
  - Grants go in the order 0001, 0010, 0100, 1000, 0001.
  - Each grant lasts 24 cycles, separated by one IDLE cycle.
- `req`=4'b0100 asserted mid-grant of requester 0:
  - `gnt` stays 0001 until `done`.
  - Requester 2 is granted in the `done` cycle, so its `gnt` appears one cycle later.
- Reset asserted at cycle 10 of a grant:
  - The next cycle shows `ld`=0, `gnt`=0, `busy`=0, `done`=0.
  - After reset is released, `req`=4'b1000 is granted with requester 0 first in round-robin order.
- With `FLASH_SCHED_LATCH_EN`, one-cycle pulse on `req[3]` during a busy grant: `gnt`=1000 after the current grant completes.
- Without `FLASH_SCHED_LATCH_EN`, the same pulse: the request is never granted.
